cdb_result_queue: RTL

- Transmit-side buffer between one functional unit (ALU, MUL or LS) and the CDB arbiter.
- Accepts completed results from the unit and holds them in a small FIFO.
- Presents the oldest result to the arbiter with a valid/ready handshake; results leave only when the arbiter grants.
- Decouples unit completion from CDB grant, so a unit that loses arbitration does not stall its own pipeline until the queue fills.
- All contents are discarded on branch_flush.

---
 rtl/cdb_result_queue.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cdb_result_queue.sv
// cdb_result_queue: transmit-side FIFO between one functional unit and the CDB
// arbiter. Completed results are buffered so that a unit which loses CDB
// arbitration keeps running until the queue fills. The oldest entry is offered
// first-word-fall-through. branch_flush discards everything.
//
// Optional feature: define CDB_QUEUE_BYPASS_EN to forward a result arriving at
// an empty queue straight onto the cdb_* outputs in the same cycle.
module cdb_result_queue #(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = 5,
    parameter int PREG_W    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     branch_flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROB_IDX_W-1:0]     in_rob_index,
    input  logic [PREG_W-1:0]        in_pd,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_rd_v,
    output logic                     cdb_valid_o,
    input  logic                     cdb_ready_i,
    output logic [ROB_IDX_W-1:0]     cdb_rob_index,
    output logic [PREG_W-1:0]        cdb_pd,
    output logic [4:0]               cdb_rd,
    output logic [31:0]              cdb_rd_v,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_index;
        logic [PREG_W-1:0]    pd;
        logic [4:0]           rd;
        logic [31:0]          rd_v;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    entry_t in_entry;
    entry_t head_entry;
    entry_t out_entry;
    logic   full;
    logic   empty;
    logic   kill;
    logic   bypass_take;
    logic   push;
    logic   pop;

    assign in_entry   = '{rob_index: in_rob_index, pd: in_pd, rd: in_rd, rd_v: in_rd_v};
    assign head_entry = mem_q[rd_ptr_q];

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // Reset and flush share one path so they can never diverge in behaviour.
    assign kill  = rst | branch_flush;

`ifdef CDB_QUEUE_BYPASS_EN
    // An arrival at an empty queue is visible to the arbiter in the same cycle.
    assign bypass_take = empty && in_valid && !kill;
`else
    assign bypass_take = 1'b0;
`endif

    // in_ready looks only at occupancy so it never waits on the arbiter's grant.
    assign in_ready    = !full;
    assign cdb_valid_o = !empty || bypass_take;
    assign pop         = !empty && cdb_ready_i;
    // A bypassed result that is granted immediately never occupies a slot.
    assign push        = in_valid && !full && !(bypass_take && cdb_ready_i);
    assign count       = count_q;

    // Select the offered entry: bypassed input, queue head, or zeros when idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        out_entry = '0;
        if (bypass_take) begin
            out_entry = in_entry;
        end else if (!empty) begin
            out_entry = head_entry;
        end
    end

    assign cdb_rob_index = out_entry.rob_index;
    assign cdb_pd        = out_entry.pd;
    assign cdb_rd        = out_entry.rd;
    assign cdb_rd_v      = out_entry.rd_v;

    // Next-state for pointers, occupancy and storage; flush/reset override traffic.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage.
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; outputs are masked by occupancy so stale entries never escape.
        mem_q <= mem_d;
    end

endmodule
